// File: rtl/rename_unit.sv
// Register rename stage: speculative/committed map tables plus a circular freelist.
// One-cycle latency from acceptance to output register; whole groups stall while outputs are held.
module rename_unit #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int PHYS_REGS            = 64,
  parameter int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid           [0:DISPATCH_WIDTH-1],
  input  logic [4:0]                      in_rs1             [0:DISPATCH_WIDTH-1],
  input  logic [4:0]                      in_rs2             [0:DISPATCH_WIDTH-1],
  input  logic [4:0]                      in_rd              [0:DISPATCH_WIDTH-1],
  output logic                            in_ready,
  output logic                            out_valid          [0:DISPATCH_WIDTH-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rs1       [0:DISPATCH_WIDTH-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rs2       [0:DISPATCH_WIDTH-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rd        [0:DISPATCH_WIDTH-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] out_old_phys_rd    [0:DISPATCH_WIDTH-1],
  input  logic                            out_ready,
  input  logic                            commit_en          [0:DISPATCH_WIDTH-1],
  input  logic [4:0]                      commit_arch_rd     [0:DISPATCH_WIDTH-1],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd     [0:DISPATCH_WIDTH-1],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] commit_old_phys_rd [0:DISPATCH_WIDTH-1],
  input  logic                            flush,
  output logic [PHYS_REGS_ADDR_WIDTH:0]   free_count
);

  localparam int AW = PHYS_REGS_ADDR_WIDTH;
  localparam int DW = DISPATCH_WIDTH;

  typedef logic [AW-1:0] tag_t;
  typedef logic [AW:0]   ptr_t;

  tag_t smt_q [32];
  tag_t smt_d [32];
  tag_t cmt_q [32];
  tag_t cmt_d [32];
  tag_t fl_q  [PHYS_REGS];
  tag_t fl_d  [PHYS_REGS];
  ptr_t head_q, head_d, tail_q, tail_d, chead_q, chead_d;

  logic out_valid_q [DW];
  logic out_valid_d [DW];
  tag_t rs1_q [DW];
  tag_t rs1_d [DW];
  tag_t rs2_q [DW];
  tag_t rs2_d [DW];
  tag_t rd_q  [DW];
  tag_t rd_d  [DW];
  tag_t old_q [DW];
  tag_t old_d [DW];

  logic lane_wr   [DW];
  tag_t lane_prd  [DW];
  tag_t lane_rs1  [DW];
  tag_t lane_rs2  [DW];
  tag_t lane_old  [DW];
  ptr_t need;
  logic out_busy;
  logic accept;

  // Allocation and intra-group bypass; later lanes see earlier lanes' new tags.
  always_comb begin
    ptr_t pos;
    pos      = head_q;
    need     = '0;
    out_busy = 1'b0;
    for (int l = 0; l < DW; l++) begin
      lane_wr[l]  = in_valid[l] && (in_rd[l] != 5'd0);
      lane_prd[l] = '0;
      if (lane_wr[l]) begin
        lane_prd[l] = fl_q[pos[AW-1:0]];
        pos         = pos + ptr_t'(1);
        need        = need + ptr_t'(1);
      end
      if (out_valid_q[l]) out_busy = 1'b1;
    end
    for (int j = 0; j < DW; j++) begin
      lane_rs1[j] = smt_q[in_rs1[j]];
      lane_rs2[j] = smt_q[in_rs2[j]];
      lane_old[j] = lane_wr[j] ? smt_q[in_rd[j]] : '0;
      for (int i = 0; i < j; i++) begin
        if (lane_wr[i]) begin
          if (in_rd[i] == in_rs1[j]) lane_rs1[j] = lane_prd[i];
          if (in_rd[i] == in_rs2[j]) lane_rs2[j] = lane_prd[i];
          if (lane_wr[j] && (in_rd[i] == in_rd[j])) lane_old[j] = lane_prd[i];
        end
      end
    end
  end

  assign free_count = tail_q - head_q;
  assign in_ready   = !flush && (!out_busy || out_ready) && (free_count >= need);
  assign accept     = in_ready;

  always_comb begin
    smt_d       = smt_q;
    cmt_d       = cmt_q;
    fl_d        = fl_q;
    head_d      = head_q;
    tail_d      = tail_q;
    chead_d     = chead_q;
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    old_d       = old_q;

    // Retirement frees the previous mapping and advances the committed head.
    for (int l = 0; l < DW; l++) begin
      if (commit_en[l] && (commit_arch_rd[l] != 5'd0)) begin
        fl_d[tail_d[AW-1:0]]      = commit_old_phys_rd[l];
        tail_d                    = tail_d + ptr_t'(1);
        chead_d                   = chead_d + ptr_t'(1);
        cmt_d[commit_arch_rd[l]]  = commit_phys_rd[l];
      end
    end

    if (flush) begin
      smt_d  = cmt_d;
      head_d = chead_d;
      for (int l = 0; l < DW; l++) out_valid_d[l] = 1'b0;
    end else if (accept) begin
      head_d = head_q + need;
      for (int l = 0; l < DW; l++) begin
        if (lane_wr[l]) smt_d[in_rd[l]] = lane_prd[l];
        out_valid_d[l] = in_valid[l];
        rs1_d[l]       = lane_rs1[l];
        rs2_d[l]       = lane_rs2[l];
        rd_d[l]        = lane_prd[l];
        old_d[l]       = lane_old[l];
      end
    end else if (out_ready) begin
      for (int l = 0; l < DW; l++) out_valid_d[l] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        smt_q[i] <= tag_t'(i);
        cmt_q[i] <= tag_t'(i);
      end
      for (int i = 0; i < PHYS_REGS; i++) begin
        fl_q[i] <= (i < PHYS_REGS - 32) ? tag_t'(i + 32) : '0;
      end
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= ptr_t'(PHYS_REGS - 32);
      for (int l = 0; l < DW; l++) begin
        out_valid_q[l] <= 1'b0;
        rs1_q[l]       <= '0;
        rs2_q[l]       <= '0;
        rd_q[l]        <= '0;
        old_q[l]       <= '0;
      end
    end else begin
      smt_q       <= smt_d;
      cmt_q       <= cmt_d;
      fl_q        <= fl_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      chead_q     <= chead_d;
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      old_q       <= old_d;
    end
  end

  always_comb begin
    for (int l = 0; l < DW; l++) begin
      out_valid[l]       = out_valid_q[l];
      out_phys_rs1[l]    = rs1_q[l];
      out_phys_rs2[l]    = rs2_q[l];
      out_phys_rd[l]     = rd_q[l];
      out_old_phys_rd[l] = old_q[l];
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: directed scenarios plus random traffic against a queue-based model.
module tb_rename_unit;

  localparam int DW = 2;
  localparam int PR = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid [0:DW-1];
  logic [4:0]    in_rs1 [0:DW-1];
  logic [4:0]    in_rs2 [0:DW-1];
  logic [4:0]    in_rd  [0:DW-1];
  logic          in_ready;
  logic          out_valid [0:DW-1];
  logic [AW-1:0] out_phys_rs1 [0:DW-1];
  logic [AW-1:0] out_phys_rs2 [0:DW-1];
  logic [AW-1:0] out_phys_rd  [0:DW-1];
  logic [AW-1:0] out_old_phys_rd [0:DW-1];
  logic          out_ready;
  logic          commit_en [0:DW-1];
  logic [4:0]    commit_arch_rd [0:DW-1];
  logic [AW-1:0] commit_phys_rd [0:DW-1];
  logic [AW-1:0] commit_old_phys_rd [0:DW-1];
  logic          flush;
  logic [AW:0]   free_count;

  rename_unit #(.DISPATCH_WIDTH(DW), .PHYS_REGS(PR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_phys_rs1(out_phys_rs1), .out_phys_rs2(out_phys_rs2),
    .out_phys_rd(out_phys_rd), .out_old_phys_rd(out_old_phys_rd),
    .out_ready(out_ready),
    .commit_en(commit_en), .commit_arch_rd(commit_arch_rd),
    .commit_phys_rd(commit_phys_rd), .commit_old_phys_rd(commit_old_phys_rd),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Reference model: map tables as plain arrays, free tags as an ordered queue,
  // tags handed out but not yet retired kept in a second queue in program order.
  typedef struct {int arch; int phys; int old;} rob_t;
  int   m_smt [32];
  int   m_cmt [32];
  int   m_fl [$];
  int   m_spec [$];
  rob_t rob [$];
  bit   mo_v [DW];
  int   mo_rs1 [DW];
  int   mo_rs2 [DW];
  int   mo_rd  [DW];
  int   mo_old [DW];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_smt[i] = i; m_cmt[i] = i; end
    m_fl.delete(); m_spec.delete(); rob.delete();
    for (int t = 32; t < PR; t++) m_fl.push_back(t);
    for (int l = 0; l < DW; l++) begin
      mo_v[l] = 0; mo_rs1[l] = 0; mo_rs2[l] = 0; mo_rd[l] = 0; mo_old[l] = 0;
    end
  endtask

  task automatic model_edge(input bit acc);
    int t;
    if (rst) begin model_reset(); return; end
    if (acc) begin
      // Lanes processed one after another give bypass and last-writer-wins directly.
      for (int l = 0; l < DW; l++) begin
        mo_v[l] = in_valid[l];
        if (in_valid[l]) begin
          mo_rs1[l] = m_smt[in_rs1[l]];
          mo_rs2[l] = m_smt[in_rs2[l]];
          if (in_rd[l] != 0) begin
            mo_old[l] = m_smt[in_rd[l]];
            t = m_fl.pop_front();
            mo_rd[l] = t;
            m_smt[in_rd[l]] = t;
            m_spec.push_back(t);
            rob.push_back('{int'(in_rd[l]), t, mo_old[l]});
          end else begin
            mo_rd[l] = 0; mo_old[l] = 0;
          end
        end
      end
    end else if (flush || out_ready) begin
      for (int l = 0; l < DW; l++) mo_v[l] = 0;
    end
    for (int l = 0; l < DW; l++) begin
      if (commit_en[l] && commit_arch_rd[l] != 0) begin
        m_cmt[commit_arch_rd[l]] = commit_phys_rd[l];
        if (m_spec.size() > 0) void'(m_spec.pop_front());
        if (rob.size() > 0) void'(rob.pop_front());
        m_fl.push_back(int'(commit_old_phys_rd[l]));
      end
    end
    if (flush) begin
      m_smt = m_cmt;
      for (int i = m_spec.size() - 1; i >= 0; i--) m_fl.push_front(m_spec[i]);
      m_spec.delete();
      rob.delete();
    end
  endtask

  // One clock: check ready mid-cycle, apply the edge to the model, check outputs after it.
  task automatic step();
    bit exp_rdy;
    int need;
    @(negedge clk);
    need = 0;
    for (int l = 0; l < DW; l++) if (in_valid[l] && in_rd[l] != 0) need++;
    exp_rdy = !flush && (!(mo_v[0] || mo_v[1]) || out_ready) && (m_fl.size() >= need);
    if (!rst) check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    model_edge(exp_rdy);
    #1;
    check("free_count", free_count, m_fl.size());
    for (int l = 0; l < DW; l++) begin
      check("out_valid", out_valid[l], mo_v[l]);
      if (mo_v[l]) begin
        check("phys_rs1", out_phys_rs1[l], mo_rs1[l]);
        check("phys_rs2", out_phys_rs2[l], mo_rs2[l]);
        check("phys_rd", out_phys_rd[l], mo_rd[l]);
        check("old_phys_rd", out_old_phys_rd[l], mo_old[l]);
      end
    end
  endtask

  task automatic clear_inputs();
    rst = 0; flush = 0; out_ready = 1;
    for (int l = 0; l < DW; l++) begin
      in_valid[l] = 0; in_rs1[l] = 0; in_rs2[l] = 0; in_rd[l] = 0;
      commit_en[l] = 0; commit_arch_rd[l] = 0; commit_phys_rd[l] = 0; commit_old_phys_rd[l] = 0;
    end
  endtask

  task automatic lane(input int l, input int rs1, input int rs2, input int rd);
    in_valid[l] = 1; in_rs1[l] = 5'(rs1); in_rs2[l] = 5'(rs2); in_rd[l] = 5'(rd);
  endtask

  task automatic commit(input int l, input int arch, input int phys, input int old);
    commit_en[l] = 1; commit_arch_rd[l] = 5'(arch);
    commit_phys_rd[l] = AW'(phys); commit_old_phys_rd[l] = AW'(old);
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1;
    step();
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    model_reset();

    // Reset state
    do_reset();
    check("rst_free", free_count, 32);
    for (int l = 0; l < DW; l++) begin
      check("rst_vld", out_valid[l], 0);
      check("rst_rd", out_phys_rd[l], 0);
      check("rst_old", out_old_phys_rd[l], 0);
    end
    #1 check("rst_rdy", in_ready, 1);

    // First group with intra-group bypass
    lane(0, 0, 0, 5); lane(1, 5, 0, 6);
    step();
    check("g1_rd0", out_phys_rd[0], 32);
    check("g1_rd1", out_phys_rd[1], 33);
    check("g1_rs1", out_phys_rs1[1], 32);
    check("g1_old0", out_old_phys_rd[0], 5);
    check("g1_old1", out_old_phys_rd[1], 6);
    check("g1_free", free_count, 30);

    // Backpressure: outputs hold, input stalls, then transfer and reload
    clear_inputs(); lane(0, 1, 2, 8); lane(1, 3, 4, 9); out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_rd0", out_phys_rd[0], 32);
      check("hold_rd1", out_phys_rd[1], 33);
      check("hold_rdy", in_ready, 0);
    end
    out_ready = 1;
    step();
    check("rel_rd0", out_phys_rd[0], 34);
    check("rel_rd1", out_phys_rd[1], 35);

    // Commit returns the old tag to the tail; drain the freelist to find it
    do_reset();
    lane(0, 0, 0, 5);
    step();
    clear_inputs(); commit(0, 5, 32, 5);
    step();
    check("cm_free", free_count, 32);
    clear_inputs();
    for (int g = 0; g < 16; g++) begin
      lane(0, 1, 2, 10); lane(1, 10, 3, 11);
      step();
    end
    check("tail_tag", out_phys_rd[1], 5);
    check("empty_free", free_count, 0);
    #1 check("empty_rdy", in_ready, 0);
    clear_inputs(); lane(0, 1, 2, 0); lane(1, 3, 4, 0);
    #1 check("x0_rdy", in_ready, 1);
    step();
    check("x0_rd", out_phys_rd[0], 0);

    // Flush after partial commit restores committed map and head
    do_reset();
    lane(0, 0, 0, 5); lane(1, 0, 0, 6);
    step();
    clear_inputs(); commit(0, 5, 32, 5);
    step();
    clear_inputs(); flush = 1;
    step();
    clear_inputs(); lane(0, 5, 0, 0); lane(1, 6, 0, 8);
    step();
    check("fl_rs5", out_phys_rs1[0], 32);
    check("fl_rs6", out_phys_rs1[1], 6);
    check("fl_alloc", out_phys_rd[1], 33);

    // Flush in the same cycle as a commit
    do_reset();
    lane(0, 0, 0, 5); lane(1, 0, 0, 6);
    step();
    clear_inputs(); lane(0, 0, 0, 7);
    step();
    clear_inputs(); commit(0, 5, 32, 5); commit(1, 6, 33, 6);
    step();
    clear_inputs(); commit(0, 7, 34, 7); flush = 1;
    step();
    check("fc_free", free_count, 32);
    clear_inputs(); lane(0, 7, 0, 0);
    step();
    check("fc_x7", out_phys_rs1[0], 34);

    // Reset mid-group dominates flush and commit
    clear_inputs(); lane(0, 1, 1, 12); lane(1, 12, 1, 13); out_ready = 0;
    step();
    clear_inputs(); rst = 1; flush = 1; commit(0, 12, 40, 12);
    step();
    check("mr_free", free_count, 32);
    check("mr_vld", out_valid[0], 0);
    clear_inputs(); lane(0, 12, 13, 0);
    step();
    check("mr_rs1", out_phys_rs1[0], 12);

    // Random traffic; commits retire from the oldest renamed writer
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int ncom;
      clear_inputs();
      for (int l = 0; l < DW; l++) begin
        if ($urandom_range(0, 9) < 7)
          lane(l, $urandom_range(0, 31), $urandom_range(0, 31),
               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      ncom = $urandom_range(0, 2);
      if (ncom > rob.size()) ncom = rob.size();
      for (int k = 0; k < ncom; k++) commit(k, rob[k].arch, rob[k].phys, rob[k].old);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
